rom_dl_sequencer: RTL and testbench
===================================

Name: rom_dl_sequencer

Overview:
- Sequences the ROM download byte stream (ioctl) into the shared SDRAM write ports and the on-chip PROM write strobe.
- Uses toggle req/ack handshakes. A small FIFO absorbs bytes that arrive while an SDRAM write is still outstanding.
- Owns the rom_loaded flag that gates core reset release.
- Sits between hps_io and the sdram block, replacing ad-hoc request toggling in the top level.

Parameters:
- FIFO_DEPTH, 4, byte entries buffered ({addr, data}); power of two.
- GFX_BASE, 25'h30000, first address also mirrored to port 2.
- PROM_BASE, 25'hA0000, first address routed to the PROM strobe.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  download active
- ioctl_index  in  8  only index 0 is accepted
- ioctl_wr  in  1  byte strobe; rising edge = one byte
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- p1_req  out  1  port-1 toggle request
- p1_ack  in  1  port-1 toggle ack
- p1_a  out  23  word address (addr[23:1])
- p1_ds  out  2  {addr[0], ~addr[0]}
- p1_d  out  16  {data, data}
- p2_req  out  1  port-2 toggle request
- p2_ack  in  1  port-2 toggle ack
- p2_a  out  23  (addr-GFX_BASE)[23:1]
- p2_ds  out  2  byte lanes of addr-GFX_BASE
- p2_d  out  16  {data, data}
- prom_wr  out  1  one-cycle PROM write pulse
- prom_addr  out  12  (addr-PROM_BASE)[11:0]
- prom_data  out  8  byte
- dl_busy  out  1  FIFO non-empty or handshake outstanding
- rom_loaded  out  1  sticky: a download completed and drained
- overflow  out  1  sticky: a byte was dropped on FIFO full

Behaviour:
- Reset: all outputs 0. FIFO empty, FSM IDLE, edge detector cleared. The sdram block is reset in the same domain, so ack inputs also return to 0.
- Accept: a byte is pushed on the cycle where ioctl_wr is 1, it was 0 the previous cycle, ioctl_download=1 and ioctl_index==0. No other strobe pushes.
- Routing, decided at pop:
  - addr < GFX_BASE: port 1 only.
  - GFX_BASE <= addr < PROM_BASE: port 1 and port 2.
  - addr >= PROM_BASE: port 1 and prom_wr.
- Port 1 always receives every byte (full image mirror).
- FSM states:
  - IDLE: if FIFO not empty, pop the head. Latch p*_a/ds/d and prom_* on the same edge. Toggle p1_req; toggle p2_req if in the GFX range; pulse prom_wr for exactly 1 cycle if in the PROM range. Go to WAIT.
  - WAIT: stay until p1_ack==p1_req and p2_ack==p2_req, then return to IDLE.
  - The IDLE→WAIT→IDLE round trip costs one idle cycle minimum. There is no back-to-back issue in the ack cycle.
- Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE produces the req toggle at edge N+1.
- Address and data outputs hold stable from the toggle until the matching ack.
- Simultaneous push and pop: both occur, and the count is unchanged.
- Full FIFO with an incoming push: the byte is dropped and overflow is set (sticky until reset). The pop in the same cycle still proceeds, so a push coinciding with a pop on a full FIFO is accepted.
- Download end: on the falling edge of ioctl_download, arm a pending_done flag. rom_loaded sets on the first cycle where pending_done=1, the FIFO is empty and the FSM is IDLE.
  - rom_loaded stays set for later downloads; it is cleared only by reset.
  - A new rising edge of ioctl_download does not clear pending_done.
- dl_busy = (FIFO count != 0) or (state == WAIT).
- Reset mid-operation: the outstanding handshake is abandoned, queued bytes are discarded, and req returns to 0.
- Address arithmetic is 25-bit unsigned. Subtraction results are used only inside their own range, so no underflow is ever exposed.

Test Plan:
- Single byte, addr 0x00005, data 0xA5, ack returned 3 cycles after req → p1_req toggles 1 cycle after the strobe; p1_a=0x000002, p1_ds=2'b10, p1_d=0xA5A5; p2_req and prom_wr unchanged; dl_busy falls the cycle after ack matches.
- Byte at 0x30010, data 0x3C → both reqs toggle; p2_a=0x000008, p2_ds=2'b01; FSM leaves WAIT only after both acks, including when p2_ack lags p1_ack by 5 cycles.
- Byte at 0xA0102, data 0x7E → prom_wr high exactly 1 cycle with prom_addr=0x102, prom_data=0x7E; p1_req toggles.
- Hold p1_ack for 20 cycles while 6 bytes strobe → first 5 bytes accepted (1 in flight + 4 queued), 6th dropped, overflow=1; the 5 accepted bytes complete in address order.
- Download falls with 3 bytes queued → rom_loaded stays 0 until the last ack, then rises 1 cycle after IDLE with FIFO empty. ioctl_index=1 strobes are never issued.
- Assert reset_n=0 during WAIT → all outputs 0 asynchronously; after release, a new byte issues normally with req toggling 0→1.

Source files
------------

// File: rtl/rom_dl_sequencer_if.sv
// Signal bundle between hps_io (ioctl download), the sdram write ports and the PROM strobe.
// The sequencer uses the master modport; the download source / sdram side uses slave.
interface rom_dl_sequencer_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic        p1_req;
    logic        p1_ack;
    logic [22:0] p1_a;
    logic [1:0]  p1_ds;
    logic [15:0] p1_d;

    logic        p2_req;
    logic        p2_ack;
    logic [22:0] p2_a;
    logic [1:0]  p2_ds;
    logic [15:0] p2_d;

    logic        prom_wr;
    logic [11:0] prom_addr;
    logic [7:0]  prom_data;

    logic        dl_busy;
    logic        rom_loaded;
    logic        overflow;

    modport master (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, p1_ack, p2_ack,
        output p1_req, p1_a, p1_ds, p1_d, p2_req, p2_a, p2_ds, p2_d,
               prom_wr, prom_addr, prom_data, dl_busy, rom_loaded, overflow
    );

    modport slave (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, p1_ack, p2_ack,
        input  p1_req, p1_a, p1_ds, p1_d, p2_req, p2_a, p2_ds, p2_d,
               prom_wr, prom_addr, prom_data, dl_busy, rom_loaded, overflow
    );
endinterface

// File: rtl/rom_dl_sequencer.sv
// ROM download sequencer: buffers ioctl bytes in a small FIFO and issues them to the sdram
// ports (toggle req/ack) and the PROM strobe; owns the sticky rom_loaded / overflow flags.
module rom_dl_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [24:0] GFX_BASE   = 25'h30000,
    parameter logic [24:0] PROM_BASE  = 25'hA0000
) (
    input logic                clk_sys,
    input logic                reset_n,
    rom_dl_sequencer_if.master bus
);
    localparam int unsigned   PtrW    = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] CntFull = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [PtrW:0] CntOne  = (PtrW + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e          r_state;
    logic            r_wr_prev, r_dl_prev, r_pending_done, r_rom_loaded, r_overflow;
    logic [24:0]     r_fifo_addr [FIFO_DEPTH];
    logic [7:0]      r_fifo_data [FIFO_DEPTH];
    logic [PtrW-1:0] r_wptr, r_rptr;
    logic [PtrW:0]   r_count;

    logic            r_p1_req, r_p2_req, r_prom_wr;
    logic [22:0]     r_p1_a, r_p2_a;
    logic [1:0]      r_p1_ds, r_p2_ds;
    logic [15:0]     r_p1_d, r_p2_d;
    logic [11:0]     r_prom_addr;
    logic [7:0]      r_prom_data;

    logic            w_push_req, w_push, w_pop, w_full, w_in_gfx, w_in_prom;
    logic [24:0]     w_head_addr;
    logic [7:0]      w_head_data;
    logic [23:0]     w_gfx_off;
    logic [11:0]     w_prom_off;

    assign w_push_req  = bus.ioctl_wr && !r_wr_prev && bus.ioctl_download
                         && (bus.ioctl_index == 8'd0);
    assign w_full      = (r_count == CntFull);
    assign w_pop       = (r_state == StIdle) && (r_count != '0);
    // A pop frees a slot on the same edge, so a full FIFO still accepts a coinciding push.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_head_addr = r_fifo_addr[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];
    assign w_in_gfx    = (w_head_addr >= GFX_BASE) && (w_head_addr < PROM_BASE);
    assign w_in_prom   = (w_head_addr >= PROM_BASE);
    assign w_gfx_off   = w_head_addr[23:0] - GFX_BASE[23:0];
    assign w_prom_off  = w_head_addr[11:0] - PROM_BASE[11:0];

    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= bus.ioctl_addr;
            r_fifo_data[r_wptr] <= bus.ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_prev      <= 1'b0;
            r_dl_prev      <= 1'b0;
            r_pending_done <= 1'b0;
            r_rom_loaded   <= 1'b0;
            r_overflow     <= 1'b0;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
        end else begin
            r_wr_prev <= bus.ioctl_wr;
            r_dl_prev <= bus.ioctl_download;
            if (r_dl_prev && !bus.ioctl_download) r_pending_done <= 1'b1;
            if (r_pending_done && (r_count == '0) && (r_state == StIdle)) r_rom_loaded <= 1'b1;
            if (w_push_req && !w_push) r_overflow <= 1'b1;
            if (w_push) r_wptr <= r_wptr + PtrOne;
            if (w_pop) r_rptr <= r_rptr + PtrOne;
            if (w_push && !w_pop) begin
                r_count <= r_count + CntOne;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CntOne;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_p1_req    <= 1'b0;
            r_p2_req    <= 1'b0;
            r_prom_wr   <= 1'b0;
            r_p1_a      <= '0;
            r_p1_ds     <= '0;
            r_p1_d      <= '0;
            r_p2_a      <= '0;
            r_p2_ds     <= '0;
            r_p2_d      <= '0;
            r_prom_addr <= '0;
            r_prom_data <= '0;
        end else begin
            r_prom_wr <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_p1_req <= ~r_p1_req;
                        r_p1_a   <= w_head_addr[23:1];
                        r_p1_ds  <= {w_head_addr[0], ~w_head_addr[0]};
                        r_p1_d   <= {w_head_data, w_head_data};
                        // Port 2 and PROM outputs only move when their own target is hit.
                        if (w_in_gfx) begin
                            r_p2_req <= ~r_p2_req;
                            r_p2_a   <= w_gfx_off[23:1];
                            r_p2_ds  <= {w_gfx_off[0], ~w_gfx_off[0]};
                            r_p2_d   <= {w_head_data, w_head_data};
                        end
                        if (w_in_prom) begin
                            r_prom_wr   <= 1'b1;
                            r_prom_addr <= w_prom_off;
                            r_prom_data <= w_head_data;
                        end
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if ((bus.p1_ack == r_p1_req) && (bus.p2_ack == r_p2_req)) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.p1_req     = r_p1_req;
    assign bus.p1_a       = r_p1_a;
    assign bus.p1_ds      = r_p1_ds;
    assign bus.p1_d       = r_p1_d;
    assign bus.p2_req     = r_p2_req;
    assign bus.p2_a       = r_p2_a;
    assign bus.p2_ds      = r_p2_ds;
    assign bus.p2_d       = r_p2_d;
    assign bus.prom_wr    = r_prom_wr;
    assign bus.prom_addr  = r_prom_addr;
    assign bus.prom_data  = r_prom_data;
    assign bus.dl_busy    = (r_count != '0) || (r_state == StWait);
    assign bus.rom_loaded = r_rom_loaded;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Bench for rom_dl_sequencer: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (byte queue, outstanding flag, sticky flags).
module tb_rom_dl_sequencer;
    localparam int unsigned Depth    = 4;
    localparam logic [24:0] GfxBase  = 25'h30000;
    localparam logic [24:0] PromBase = 25'hA0000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    rom_dl_sequencer_if bus ();

    rom_dl_sequencer #(
        .FIFO_DEPTH(Depth),
        .GFX_BASE  (GfxBase),
        .PROM_BASE (PromBase)
    ) dut (
        .clk_sys(clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: bytes accepted but not yet issued, plus the byte currently in flight.
    logic [24:0] q_addr[$];
    logic [7:0]  q_data[$];
    bit          m_wait, m_p1_req, m_p2_req, m_prom_wr, m_overflow, m_loaded, m_pending;
    bit          m_wr_prev, m_dl_prev, m_gfx;
    logic [24:0] m_addr;
    logic [7:0]  m_data;
    int          p1_lat, p2_lat, p1_cnt, p2_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_addr.delete();
        q_data.delete();
        {m_wait, m_p1_req, m_p2_req, m_prom_wr, m_overflow, m_loaded, m_pending} = '0;
        {m_wr_prev, m_dl_prev, m_gfx} = '0;
        m_addr = '0;
        m_data = '0;
        p1_cnt = 0;
        p2_cnt = 0;
        bus.p1_ack = 1'b0;
        bus.p2_ack = 1'b0;
    endtask

    task automatic respond();
        if (bus.p1_ack != m_p1_req) begin
            if (p1_cnt <= 0) bus.p1_ack = m_p1_req;
            else p1_cnt--;
        end
        if (bus.p2_ack != m_p2_req) begin
            if (p2_cnt <= 0) bus.p2_ack = m_p2_req;
            else p2_cnt--;
        end
    endtask

    task automatic model_step();
        int sz;
        bit pop, push_req;
        sz       = q_addr.size();
        push_req = bus.ioctl_wr && !m_wr_prev && bus.ioctl_download && (bus.ioctl_index == 8'd0);
        pop      = !m_wait && (sz > 0);
        m_prom_wr = 1'b0;
        if (m_pending && (sz == 0) && !m_wait) m_loaded = 1'b1;
        if (m_dl_prev && !bus.ioctl_download) m_pending = 1'b1;
        if (m_wait) begin
            if ((bus.p1_ack == m_p1_req) && (bus.p2_ack == m_p2_req)) m_wait = 1'b0;
        end else if (pop) begin
            m_addr   = q_addr.pop_front();
            m_data   = q_data.pop_front();
            m_wait   = 1'b1;
            m_p1_req = !m_p1_req;
            p1_cnt   = (p1_lat < 0) ? int'($urandom_range(3, 0)) : p1_lat;
            m_gfx    = (m_addr >= GfxBase) && (m_addr < PromBase);
            if (m_gfx) begin
                m_p2_req = !m_p2_req;
                p2_cnt   = (p2_lat < 0) ? int'($urandom_range(6, 0)) : p2_lat;
            end
            if (m_addr >= PromBase) m_prom_wr = 1'b1;
        end
        if (push_req) begin
            if ((sz < int'(Depth)) || pop) begin
                q_addr.push_back(bus.ioctl_addr);
                q_data.push_back(bus.ioctl_dout);
            end else begin
                m_overflow = 1'b1;
            end
        end
        m_wr_prev = bus.ioctl_wr;
        m_dl_prev = bus.ioctl_download;
    endtask

    task automatic check_outputs();
        logic [24:0] off;
        check_eq("p1_req", 32'(bus.p1_req), 32'(m_p1_req));
        check_eq("p2_req", 32'(bus.p2_req), 32'(m_p2_req));
        check_eq("prom_wr", 32'(bus.prom_wr), 32'(m_prom_wr));
        check_eq("overflow", 32'(bus.overflow), 32'(m_overflow));
        check_eq("rom_loaded", 32'(bus.rom_loaded), 32'(m_loaded));
        check_eq("dl_busy", 32'(bus.dl_busy), 32'((q_addr.size() != 0) || m_wait));
        if (m_wait) begin
            check_eq("p1_a", 32'(bus.p1_a), (32'(m_addr) >> 1) & 32'h7F_FFFF);
            check_eq("p1_ds", 32'(bus.p1_ds), (m_addr % 2 == 1) ? 32'h2 : 32'h1);
            check_eq("p1_d", 32'(bus.p1_d), 32'(m_data) * 32'h101);
            if (m_gfx) begin
                off = m_addr - GfxBase;
                check_eq("p2_a", 32'(bus.p2_a), (32'(off) >> 1) & 32'h7F_FFFF);
                check_eq("p2_ds", 32'(bus.p2_ds), (off % 2 == 1) ? 32'h2 : 32'h1);
                check_eq("p2_d", 32'(bus.p2_d), 32'(m_data) * 32'h101);
            end
        end
        if (m_prom_wr) begin
            off = m_addr - PromBase;
            check_eq("prom_addr", 32'(bus.prom_addr), 32'(off) % 4096);
            check_eq("prom_data", 32'(bus.prom_data), 32'(m_data));
        end
    endtask

    task automatic check_reset();
        check_eq("rst_p1_req", 32'(bus.p1_req), 0);
        check_eq("rst_p2_req", 32'(bus.p2_req), 0);
        check_eq("rst_prom_wr", 32'(bus.prom_wr), 0);
        check_eq("rst_p1_a", 32'(bus.p1_a), 0);
        check_eq("rst_p2_a", 32'(bus.p2_a), 0);
        check_eq("rst_prom_addr", 32'(bus.prom_addr), 0);
        check_eq("rst_dl_busy", 32'(bus.dl_busy), 0);
        check_eq("rst_rom_loaded", 32'(bus.rom_loaded), 0);
        check_eq("rst_overflow", 32'(bus.overflow), 0);
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic step();
        respond();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic strobe(input logic [24:0] addr, input logic [7:0] data, input logic [7:0] idx);
        bus.ioctl_addr  = addr;
        bus.ioctl_dout  = data;
        bus.ioctl_index = idx;
        bus.ioctl_wr    = 1'b1;
        step();
        bus.ioctl_wr = 1'b0;
        step();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (m_wait || q_addr.size() != 0); i++) step();
        check_eq("drain_done", 32'(m_wait || q_addr.size() != 0), 0);
        step();
    endtask

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        p1_lat = 3;
        p2_lat = 0;
        model_reset();
        @(negedge clk);
        check_reset();
        reset_n = 1'b1;
        bus.ioctl_download = 1'b1;
        step();

        // Single port-1 byte; req toggles on the edge after the strobe edge.
        strobe(25'h00005, 8'hA5, 8'd0);
        check_eq("t1_p1_req", 32'(bus.p1_req), 1);
        check_eq("t1_p1_a", 32'(bus.p1_a), 32'h2);
        check_eq("t1_p1_ds", 32'(bus.p1_ds), 32'h2);
        check_eq("t1_p1_d", 32'(bus.p1_d), 32'hA5A5);
        check_eq("t1_p2_req", 32'(bus.p2_req), 0);
        drain(20);
        check_eq("t1_busy_low", 32'(bus.dl_busy), 0);

        // GFX byte: both ports, port-2 ack lagging port-1 by 5 cycles.
        p1_lat = 1;
        p2_lat = 6;
        strobe(25'h30010, 8'h3C, 8'd0);
        check_eq("t2_p2_req", 32'(bus.p2_req), 1);
        check_eq("t2_p2_a", 32'(bus.p2_a), 32'h8);
        check_eq("t2_p2_ds", 32'(bus.p2_ds), 32'h1);
        drain(30);

        // PROM byte: one-cycle strobe.
        p1_lat = 2;
        strobe(25'hA0102, 8'h7E, 8'd0);
        check_eq("t3_prom_wr", 32'(bus.prom_wr), 1);
        check_eq("t3_prom_addr", 32'(bus.prom_addr), 32'h102);
        check_eq("t3_prom_data", 32'(bus.prom_data), 32'h7E);
        step();
        check_eq("t3_prom_wr_low", 32'(bus.prom_wr), 0);
        drain(20);

        // Port-1 ack held off: 1 in flight + 4 queued, sixth byte dropped.
        p1_lat = 20;
        for (int i = 0; i < 6; i++) strobe(25'h100 + 25'(i), 8'(8'h10 + i), 8'd0);
        check_eq("t4_overflow", 32'(bus.overflow), 1);
        p1_lat = 1;
        drain(100);

        // Download end with bytes queued; index-1 strobes are ignored.
        p1_lat = 3;
        strobe(25'h300, 8'h11, 8'd1);
        strobe(25'h301, 8'h22, 8'd1);
        for (int i = 0; i < 4; i++) strobe(25'h200 + 25'(i), 8'(8'h40 + i), 8'd0);
        bus.ioctl_download = 1'b0;
        step();
        check_eq("t5_not_loaded", 32'(bus.rom_loaded), 0);
        for (int i = 0; i < 100 && !m_loaded; i++) step();
        check_eq("t5_loaded", 32'(bus.rom_loaded), 1);
        bus.ioctl_download = 1'b1;
        step();

        // Random traffic over all three regions with random ack latencies.
        p1_lat = -1;
        p2_lat = -1;
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(2, 0))
                0: bus.ioctl_addr = 25'($urandom_range(32'(GfxBase) - 1, 0));
                1: bus.ioctl_addr = GfxBase + 25'($urandom_range(32'h6FFFF, 0));
                default: bus.ioctl_addr = PromBase + 25'($urandom_range(32'h1FFFF, 0));
            endcase
            bus.ioctl_dout  = 8'($urandom);
            bus.ioctl_index = ($urandom_range(7, 0) == 0) ? 8'd1 : 8'd0;
            bus.ioctl_wr    = 1'($urandom);
            if ($urandom_range(59, 0) == 0) bus.ioctl_download = !bus.ioctl_download;
            step();
        end
        bus.ioctl_wr = 1'b0;
        bus.ioctl_download = 1'b1;
        p1_lat = 1;
        p2_lat = 1;
        drain(100);

        // Reset in the middle of a handshake.
        p1_lat = 5;
        strobe(25'h00010, 8'h55, 8'd0);
        check_eq("t6_in_wait", 32'(bus.dl_busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset();
        model_reset();
        bus.ioctl_wr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        p1_lat = 2;
        strobe(25'h00042, 8'h99, 8'd0);
        check_eq("t6_req_after_rst", 32'(bus.p1_req), 1);
        check_eq("t6_p1_d", 32'(bus.p1_d), 32'h9999);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
